bpm_digit_renderer: RTL and testbench

BPM_DIGIT_RENDERER -- requirements
Module: bpm_digit_renderer

---
 rtl/bpm_digit_renderer.sv | 200 ++++++++++++++++++++
 tb/tb_bpm_digit_renderer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpm_digit_renderer.sv
// rtl/bpm_digit_renderer.sv - BPM value to three sprite digits with frame-synchronous layout swap
module bpm_digit_renderer #(
    parameter int ORIGIN_X = 100,
    parameter int ORIGIN_Y = 50,
    parameter int SHEET_W  = 640
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  value,
    input  logic        value_valid,
    output logic        busy,
    output logic        dropped,
    output logic [3:0]  number,
    input  logic [10:0] sprite_x_left,
    input  logic [10:0] sprite_x_right,
    input  logic [10:0] sprite_y_top,
    input  logic [10:0] sprite_y_bottom,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [18:0] rom_addr,
    output logic        pixel_en
);
    typedef enum logic [2:0] {IDLE, CONV, REQ, CAP, COMMIT} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  slot;
    logic [21:0] sr;
    logic [21:0] sr_next;
    logic        pending_ready;
    logic [10:0] cap_l[3], cap_r[3], cap_t[3], cap_b[3];
    logic [10:0] pend_x[3], pend_w[3], pend_h[3], pend_l[3], pend_t[3];
    logic [10:0] act_x[3], act_w[3], act_h[3], act_l[3], act_t[3];
    logic [10:0] lay_x[3], lay_w[3];

    // One shift-add-3 iteration: BCD nibbles live in [21:10], binary in [9:0].
    function automatic logic [21:0] bcd_step(input logic [21:0] s);
        logic [21:0] a;
        a = s;
        for (int i = 0; i < 3; i++) begin
            if (a[10+4*i +: 4] >= 4'd5)
                a[10+4*i +: 4] = a[10+4*i +: 4] + 4'd3;
        end
        return {a[20:0], 1'b0};
    endfunction

    assign sr_next = bcd_step(sr);

    // Leading-zero suppression; a suppressed slot collapses to zero width.
    always_comb begin
        lay_w[0] = (sr[21:18] == 4'd0) ? 11'd0 : cap_r[0] - cap_l[0];
        lay_w[1] = (sr[21:14] == 8'd0) ? 11'd0 : cap_r[1] - cap_l[1];
        lay_w[2] = cap_r[2] - cap_l[2];
        lay_x[0] = 11'(ORIGIN_X);
        lay_x[1] = 11'(ORIGIN_X) + lay_w[0];
        lay_x[2] = 11'(ORIGIN_X) + lay_w[0] + lay_w[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            slot          <= 2'd0;
            sr            <= 22'd0;
            busy          <= 1'b0;
            dropped       <= 1'b0;
            number        <= 4'd0;
            pending_ready <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                cap_l[k]  <= 11'd0;
                cap_r[k]  <= 11'd0;
                cap_t[k]  <= 11'd0;
                cap_b[k]  <= 11'd0;
                pend_x[k] <= 11'd0;
                pend_w[k] <= 11'd0;
                pend_h[k] <= 11'd0;
                pend_l[k] <= 11'd0;
                pend_t[k] <= 11'd0;
                act_x[k]  <= 11'd0;
                act_w[k]  <= 11'd0;
                act_h[k]  <= 11'd0;
                act_l[k]  <= 11'd0;
                act_t[k]  <= 11'd0;
            end
        end else begin
            dropped <= value_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (value_valid) begin
                        sr    <= {12'd0, (value > 10'd999) ? 10'd999 : value};
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sr  <= sr_next;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        number <= sr_next[21:18];
                        slot   <= 2'd0;
                        state  <= REQ;
                    end
                end
                REQ: state <= CAP;
                CAP: begin
                    cap_l[slot] <= sprite_x_left;
                    cap_r[slot] <= sprite_x_right;
                    cap_t[slot] <= sprite_y_top;
                    cap_b[slot] <= sprite_y_bottom;
                    if (slot == 2'd2) begin
                        state <= COMMIT;
                    end else begin
                        number <= (slot == 2'd0) ? sr[17:14] : sr[13:10];
                        slot   <= slot + 2'd1;
                        state  <= REQ;
                    end
                end
                COMMIT: begin
                    for (int k = 0; k < 3; k++) begin
                        pend_x[k] <= lay_x[k];
                        pend_w[k] <= lay_w[k];
                        pend_h[k] <= cap_b[k] - cap_t[k];
                        pend_l[k] <= cap_l[k];
                        pend_t[k] <= cap_t[k];
                    end
                    pending_ready <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Swap only on the frame-origin pixel so a frame never mixes layouts.
            if (hcount == 11'd0 && vcount == 10'd0 && pending_ready) begin
                for (int k = 0; k < 3; k++) begin
                    act_x[k] <= pend_x[k];
                    act_w[k] <= pend_w[k];
                    act_h[k] <= pend_h[k];
                    act_l[k] <= pend_l[k];
                    act_t[k] <= pend_t[k];
                end
                if (state != COMMIT)
                    pending_ready <= 1'b0;
            end
        end
    end

    logic [10:0] h_q;
    logic [9:0]  v_q;
    logic        hit, s1_hit;
    logic [10:0] dx, dy, sel_l, sel_t;
    logic [10:0] s1_dx, s1_dy, s1_l, s1_t;
    logic [18:0] addr_c;

    always_comb begin
        hit   = 1'b0;
        dx    = 11'd0;
        dy    = 11'd0;
        sel_l = 11'd0;
        sel_t = 11'd0;
        for (int k = 0; k < 3; k++) begin
            if (act_w[k] != 11'd0 && h_q >= act_x[k] &&
                {1'b0, h_q} < {1'b0, act_x[k]} + {1'b0, act_w[k]} &&
                {1'b0, v_q} >= 11'(ORIGIN_Y) &&
                {2'b0, v_q} < 12'(ORIGIN_Y) + {1'b0, act_h[k]}) begin
                hit   = 1'b1;
                dx    = h_q - act_x[k];
                dy    = {1'b0, v_q} - 11'(ORIGIN_Y);
                sel_l = act_l[k];
                sel_t = act_t[k];
            end
        end
    end

    assign addr_c = (19'(s1_t) + 19'(s1_dy)) * 19'(SHEET_W) + 19'(s1_l) + 19'(s1_dx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q      <= 11'd0;
            v_q      <= 10'd0;
            s1_hit   <= 1'b0;
            s1_dx    <= 11'd0;
            s1_dy    <= 11'd0;
            s1_l     <= 11'd0;
            s1_t     <= 11'd0;
            rom_addr <= 19'd0;
            pixel_en <= 1'b0;
        end else begin
            h_q      <= hcount;
            v_q      <= vcount;
            s1_hit   <= hit;
            s1_dx    <= dx;
            s1_dy    <= dy;
            s1_l     <= sel_l;
            s1_t     <= sel_t;
            rom_addr <= s1_hit ? addr_c : 19'd0;
            pixel_en <= s1_hit;
        end
    end
endmodule

// File: tb/tb_bpm_digit_renderer.sv
// tb/tb_bpm_digit_renderer.sv - randomized self-checking bench with sprite map and layout model
module tb_bpm_digit_renderer;
    localparam int NEUT_X = 1000;
    localparam int NEUT_Y = 600;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  value;
    logic        value_valid;
    logic        busy, dropped, pixel_en;
    logic [3:0]  number;
    logic [10:0] sprite_x_left, sprite_x_right, sprite_y_top, sprite_y_bottom;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [18:0] rom_addr;

    int total = 0;
    int bad   = 0;
    int act_x[3], act_w[3], act_h[3], act_l[3], act_t[3];
    int pend_x[3], pend_w[3], pend_h[3], pend_l[3], pend_t[3];
    bit pend_rdy;

    always #5 clk = ~clk;

    bpm_digit_renderer dut (
        .clk(clk), .reset_n(reset_n), .value(value), .value_valid(value_valid),
        .busy(busy), .dropped(dropped), .number(number),
        .sprite_x_left(sprite_x_left), .sprite_x_right(sprite_x_right),
        .sprite_y_top(sprite_y_top), .sprite_y_bottom(sprite_y_bottom),
        .hcount(hcount), .vcount(vcount), .rom_addr(rom_addr), .pixel_en(pixel_en)
    );

    function automatic int spr_w(input int d);
        case (d)
            0: return 41;  1: return 30;  2: return 50;  3: return 48;  4: return 47;
            5: return 46;  6: return 49;  7: return 45;  8: return 51;  9: return 52;
            default: return 0;
        endcase
    endfunction

    function automatic int spr_l(input int d);
        case (d)
            0: return 567; 1: return 10;  2: return 60;  3: return 110; 4: return 160;
            5: return 210; 6: return 260; 7: return 419; 8: return 310; 9: return 360;
            default: return 0;
        endcase
    endfunction

    function automatic int spr_t(input int d);
        return (d == 1 || d == 4) ? 200 : 281;
    endfunction

    // Sprite map block: registered lookup, valid one cycle after number changes.
    always @(posedge clk) begin
        sprite_x_left   <= 11'(spr_l(int'(number)));
        sprite_x_right  <= 11'(spr_l(int'(number)) + spr_w(int'(number)));
        sprite_y_top    <= 11'(spr_t(int'(number)));
        sprite_y_bottom <= 11'(spr_t(int'(number)) + 60 + int'(number));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_commit(input int v);
        int vv, x;
        int d[3];
        bit shown;
        vv = (v > 999) ? 999 : v;
        d[0] = vv / 100;
        d[1] = (vv / 10) % 10;
        d[2] = vv % 10;
        x = 100;
        for (int k = 0; k < 3; k++) begin
            shown = (k == 2) || (k == 1 && (d[0] != 0 || d[1] != 0)) || (k == 0 && d[0] != 0);
            pend_x[k] = x;
            pend_w[k] = shown ? spr_w(d[k]) : 0;
            pend_h[k] = 60 + d[k];
            pend_l[k] = spr_l(d[k]);
            pend_t[k] = spr_t(d[k]);
            x += pend_w[k];
        end
        pend_rdy = 1'b1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            act_x[k] = 0; act_w[k] = 0; act_h[k] = 0; act_l[k] = 0; act_t[k] = 0;
            pend_x[k] = 0; pend_w[k] = 0; pend_h[k] = 0; pend_l[k] = 0; pend_t[k] = 0;
        end
        pend_rdy = 1'b0;
    endtask

    task automatic expect_pix(input int x, input int y, output int en, output int addr);
        en = 0;
        addr = 0;
        for (int k = 0; k < 3; k++) begin
            if (act_w[k] > 0 && x >= act_x[k] && x < act_x[k] + act_w[k] &&
                y >= 50 && y < 50 + act_h[k]) begin
                en = 1;
                addr = ((act_t[k] + y - 50) * 640 + act_l[k] + x - act_x[k]) % 524288;
            end
        end
    endtask

    task automatic probe(input int x, input int y);
        int en, addr;
        hcount = 11'(x);
        vcount = 10'(y);
        @(posedge clk); #1;
        if (x == 0 && y == 0 && pend_rdy) begin
            act_x = pend_x; act_w = pend_w; act_h = pend_h; act_l = pend_l; act_t = pend_t;
            pend_rdy = 1'b0;
        end
        hcount = 11'(NEUT_X);
        vcount = 10'(NEUT_Y);
        @(posedge clk);
        @(posedge clk); #1;
        expect_pix(x, y, en, addr);
        chk("pixel_en", pixel_en, en);
        chk("rom_addr", rom_addr, addr);
    endtask

    task automatic probe_edges();
        for (int k = 0; k < 3; k++) begin
            if (act_w[k] > 0) begin
                probe(act_x[k], 50);
                probe(act_x[k] + act_w[k] - 1, 50 + act_h[k] - 1);
                probe(act_x[k] + act_w[k], 50 + act_h[k]);
            end
        end
        probe(99, 50);
        probe(100, 49);
    endtask

    task automatic start_load(input int v);
        @(posedge clk); #1;
        value = 10'(v);
        value_valid = 1'b1;
        @(posedge clk); #1;
        value_valid = 1'b0;
    endtask

    task automatic run_load(input int v, input int inject);
        int cyc, vv;
        int d[3];
        vv = (v > 999) ? 999 : v;
        d[0] = vv / 100;
        d[1] = (vv / 10) % 10;
        d[2] = vv % 10;
        start_load(v);
        chk("dropped_idle", dropped, 0);
        cyc = 0;
        while (busy && cyc < 40) begin
            if (cyc == 10) chk("number_h", number, d[0]);
            if (cyc == 12) chk("number_t", number, d[1]);
            if (cyc == 14) chk("number_o", number, d[2]);
            if (inject >= 0 && cyc == inject + 1) begin
                chk("dropped_pulse", dropped, 1);
                value_valid = 1'b0;
            end
            if (inject >= 0 && cyc == inject) begin
                value = 10'd900;
                value_valid = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy_len", cyc, 17);
        model_commit(v);
    endtask

    initial begin
        reset_n = 1'b0;
        value = 10'd0;
        value_valid = 1'b0;
        hcount = 11'(NEUT_X);
        vcount = 10'(NEUT_Y);
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_number", number, 0);
        chk("rst_rom", rom_addr, 0);
        chk("rst_pix", pixel_en, 0);
        reset_n = 1'b1;

        run_load(72, -1);
        probe(100, 50);
        probe(0, 0);
        probe(100, 50);
        chk("v72_rom", rom_addr, 180259);
        chk("v72_en", pixel_en, 1);
        probe(144, 50); probe(145, 50); probe(194, 50); probe(195, 50);

        run_load(0, -1);
        probe(0, 0);
        probe(140, 50);
        chk("v0_rom", rom_addr, 180447);
        probe(141, 50);
        chk("v0_edge_en", pixel_en, 0);

        run_load(1000, -1);
        probe(0, 0);
        probe(151, 50); probe(152, 50); probe(203, 50); probe(204, 50);
        probe(255, 50); probe(256, 50);

        run_load(345, 3);
        probe(0, 0);
        probe_edges();

        run_load(508, -1);
        probe(150, 60); probe(180, 55);
        probe(0, 0);
        probe(150, 60); probe(180, 55);
        probe_edges();

        hcount = 11'd100;
        vcount = 10'd50;
        start_load(61);
        repeat (13) @(posedge clk);
        #1;
        chk("pre_rst_pix", pixel_en, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_number", number, 0);
        chk("mid_rst_pix", pixel_en, 0);
        chk("mid_rst_rom", rom_addr, 0);
        chk("mid_rst_dropped", dropped, 0);
        model_clear();
        hcount = 11'(NEUT_X);
        vcount = 10'(NEUT_Y);
        @(posedge clk); #1;
        reset_n = 1'b1;
        probe(0, 0);
        probe(100, 50);
        run_load(61, -1);
        probe(100, 50);
        probe(0, 0);
        probe(100, 50);
        probe_edges();

        for (int it = 0; it < 8; it++) begin
            run_load(int'($urandom_range(0, 1023)), -1);
            if ($urandom_range(0, 2) == 0)
                run_load(int'($urandom_range(0, 1023)), int'($urandom_range(0, 8)));
            probe(0, 0);
            probe_edges();
            for (int j = 0; j < 6; j++)
                probe(int'($urandom_range(90, 270)), int'($urandom_range(45, 125)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
